// File: rtl/pipeline_hazard_controller.sv
// ============================================================================
// pipeline_hazard_controller
// Hazard/sequencing control for the five-stage pipeline: load-use stall,
// taken-beq flush, memory-busy freeze, memory hang detection, perf counters.
// Revision: 1.0
// ============================================================================
`default_nettype none

module pipeline_hazard_controller #(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        clear_counters_i,
    input  logic [4:0]  if_id_rs1_i,
    input  logic [4:0]  if_id_rs2_i,
    input  logic        if_id_uses_rs2_i,
    input  logic        id_ex_mem_read_i,
    input  logic [4:0]  id_ex_rd_i,
    input  logic        ex_mem_mem_read_i,
    input  logic        ex_mem_mem_write_i,
    input  logic        ex_mem_beq_instruction_i,
    input  logic        ex_mem_flag_beq_i,
    input  logic        mem_ready_i,
    output logic        pc_write_o,
    output logic        pc_src_branch_o,
    output logic        if_id_write_o,
    output logic        id_ex_write_o,
    output logic        ex_mem_write_o,
    output logic        if_id_flush_o,
    output logic        id_ex_flush_o,
    output logic        ex_mem_flush_o,
    output logic        mem_wb_bubble_o,
    output logic        mem_error_o,
    output logic [1:0]  state_o,
    output logic [15:0] stall_cycles_o,
    output logic [15:0] flush_count_o
);

    localparam logic [1:0]  ST_RUN    = 2'd0;
    localparam logic [1:0]  ST_WAIT   = 2'd1;
    localparam logic [1:0]  ST_ERROR  = 2'd2;
    localparam logic [15:0] C_TIMEOUT = 16'(MEM_TIMEOUT);
    localparam logic [15:0] C_SAT     = 16'hFFFF;

    logic [1:0]  state_q, state_d;
    logic [15:0] wait_cnt_q, wait_cnt_d;
    logic [15:0] stall_q, stall_d;
    logic [15:0] flush_q, flush_d;
    logic        mem_error_q, mem_error_d;

    logic w_mem_busy, w_br_taken, w_load_use, w_running;
    logic w_stall_ev, w_flush_ev;

    assign w_mem_busy = (ex_mem_mem_read_i | ex_mem_mem_write_i) & ~mem_ready_i;
    assign w_br_taken = ex_mem_beq_instruction_i & ex_mem_flag_beq_i;
    assign w_load_use = id_ex_mem_read_i & (id_ex_rd_i != 5'd0) &
                        ((id_ex_rd_i == if_id_rs1_i) |
                         (if_id_uses_rs2_i & (id_ex_rd_i == if_id_rs2_i)));
    assign w_running  = (state_q != ST_ERROR);

    // Events follow the same priority as the control actions they select.
    assign w_stall_ev = w_running & (w_mem_busy | (~w_br_taken & w_load_use));
    assign w_flush_ev = w_running & ~w_mem_busy & w_br_taken;

    always_comb begin
        pc_write_o      = 1'b1;
        pc_src_branch_o = 1'b0;
        if_id_write_o   = 1'b1;
        id_ex_write_o   = 1'b1;
        ex_mem_write_o  = 1'b1;
        if_id_flush_o   = 1'b0;
        id_ex_flush_o   = 1'b0;
        ex_mem_flush_o  = 1'b0;
        mem_wb_bubble_o = 1'b0;
        if (!w_running || w_mem_busy) begin
            pc_write_o      = 1'b0;
            if_id_write_o   = 1'b0;
            id_ex_write_o   = 1'b0;
            ex_mem_write_o  = 1'b0;
            mem_wb_bubble_o = 1'b1;
        end else if (w_br_taken) begin
            pc_src_branch_o = 1'b1;
            if_id_flush_o   = 1'b1;
            id_ex_flush_o   = 1'b1;
            ex_mem_flush_o  = 1'b1;
        end else if (w_load_use) begin
            pc_write_o      = 1'b0;
            if_id_write_o   = 1'b0;
            id_ex_flush_o   = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        mem_error_d = mem_error_q;
        case (state_q)
            ST_RUN: begin
                if (w_mem_busy) begin
                    state_d    = ST_WAIT;
                    wait_cnt_d = 16'd1;
                end
            end
            ST_WAIT: begin
                if (!w_mem_busy) begin
                    state_d    = ST_RUN;
                    wait_cnt_d = 16'd0;
                end else if (wait_cnt_q == C_TIMEOUT) begin
                    state_d     = ST_ERROR;
                    mem_error_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 16'd1;
                end
            end
            default: state_d = ST_ERROR;
        endcase
    end

    always_comb begin
        stall_d = stall_q;
        flush_d = flush_q;
        if (w_running) begin
            if (clear_counters_i) begin
                stall_d = 16'd0;
                flush_d = 16'd0;
            end else begin
                if (w_stall_ev && stall_q != C_SAT) stall_d = stall_q + 16'd1;
                if (w_flush_ev && flush_q != C_SAT) flush_d = flush_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= ST_RUN;
            wait_cnt_q  <= 16'd0;
            stall_q     <= 16'd0;
            flush_q     <= 16'd0;
            mem_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            stall_q     <= stall_d;
            flush_q     <= flush_d;
            mem_error_q <= mem_error_d;
        end
    end

    assign state_o        = state_q;
    assign mem_error_o    = mem_error_q;
    assign stall_cycles_o = stall_q;
    assign flush_count_o  = flush_q;

endmodule

`default_nettype wire

// File: tb/tb_pipeline_hazard_controller.sv
// ============================================================================
// tb_pipeline_hazard_controller
// Directed vectors; expected responses queued by the driver, checked by a monitor.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_pipeline_hazard_controller;

    // {pc_write, pc_src_branch, if_id_w, id_ex_w, ex_mem_w,
    //  if_id_f, id_ex_f, ex_mem_f, mem_wb_bubble}
    localparam logic [8:0] C_NONE = 9'b1_0_111_000_0;
    localparam logic [8:0] C_BUSY = 9'b0_0_000_000_1;
    localparam logic [8:0] C_BR   = 9'b1_1_111_111_0;
    localparam logic [8:0] C_LU   = 9'b0_0_011_010_0;
    localparam logic [8:0] C_ERR  = 9'b0_0_000_000_1;

    typedef struct {
        string       name;
        logic [8:0]  ctrl;
        logic [1:0]  st;
        logic [15:0] stall;
        logic [15:0] flush;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    logic        clock_i = 1'b0;
    logic        reset_i = 1'b1;
    logic        clear_counters_i = 1'b0;
    logic [4:0]  if_id_rs1_i = '0, if_id_rs2_i = '0, id_ex_rd_i = '0;
    logic        if_id_uses_rs2_i = 1'b0, id_ex_mem_read_i = 1'b0;
    logic        ex_mem_mem_read_i = 1'b0, ex_mem_mem_write_i = 1'b0;
    logic        ex_mem_beq_instruction_i = 1'b0, ex_mem_flag_beq_i = 1'b0;
    logic        mem_ready_i = 1'b0;
    logic        pc_write_o, pc_src_branch_o, if_id_write_o, id_ex_write_o;
    logic        ex_mem_write_o, if_id_flush_o, id_ex_flush_o, ex_mem_flush_o;
    logic        mem_wb_bubble_o, mem_error_o;
    logic [1:0]  state_o;
    logic [15:0] stall_cycles_o, flush_count_o;

    pipeline_hazard_controller #(.MEM_TIMEOUT(4)) dut (
        .clock_i(clock_i), .reset_i(reset_i), .clear_counters_i(clear_counters_i),
        .if_id_rs1_i(if_id_rs1_i), .if_id_rs2_i(if_id_rs2_i),
        .if_id_uses_rs2_i(if_id_uses_rs2_i), .id_ex_mem_read_i(id_ex_mem_read_i),
        .id_ex_rd_i(id_ex_rd_i), .ex_mem_mem_read_i(ex_mem_mem_read_i),
        .ex_mem_mem_write_i(ex_mem_mem_write_i),
        .ex_mem_beq_instruction_i(ex_mem_beq_instruction_i),
        .ex_mem_flag_beq_i(ex_mem_flag_beq_i), .mem_ready_i(mem_ready_i),
        .pc_write_o(pc_write_o), .pc_src_branch_o(pc_src_branch_o),
        .if_id_write_o(if_id_write_o), .id_ex_write_o(id_ex_write_o),
        .ex_mem_write_o(ex_mem_write_o), .if_id_flush_o(if_id_flush_o),
        .id_ex_flush_o(id_ex_flush_o), .ex_mem_flush_o(ex_mem_flush_o),
        .mem_wb_bubble_o(mem_wb_bubble_o), .mem_error_o(mem_error_o),
        .state_o(state_o), .stall_cycles_o(stall_cycles_o),
        .flush_count_o(flush_count_o)
    );

    always #5 clock_i = ~clock_i;

    // Monitor: outputs are presented every cycle and sampled on the falling edge.
    always @(negedge clock_i) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            logic [8:0] act;
            e   = exp_q.pop_front();
            act = {pc_write_o, pc_src_branch_o, if_id_write_o, id_ex_write_o,
                   ex_mem_write_o, if_id_flush_o, id_ex_flush_o, ex_mem_flush_o,
                   mem_wb_bubble_o};
            checks = checks + 1;
            if (act !== e.ctrl || state_o !== e.st || stall_cycles_o !== e.stall ||
                flush_count_o !== e.flush || mem_error_o !== e.err) begin
                errors = errors + 1;
                $display("FAIL %s: ctrl=%b st=%0d stall=%0d flush=%0d err=%b, expected ctrl=%b st=%0d stall=%0d flush=%0d err=%b",
                         e.name, act, state_o, stall_cycles_o, flush_count_o, mem_error_o,
                         e.ctrl, e.st, e.stall, e.flush, e.err);
            end
        end
    end

    // One cycle of stimulus: rs1, rs2, uses_rs2, id_ex load, rd, mem rd/wr,
    // beq, flag, mem_ready, clear, reset; then the expected response.
    task automatic step(input string nm,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic u2,
                        input logic idr, input logic [4:0] rd,
                        input logic mr, input logic mw, input logic beq, input logic flg,
                        input logic rdy, input logic clr, input logic rst,
                        input logic [8:0] ec, input logic [1:0] es,
                        input int est, input int efl, input logic eerr);
        exp_t e;
        @(posedge clock_i);
        #1;
        reset_i = rst;
        if_id_rs1_i = rs1; if_id_rs2_i = rs2; if_id_uses_rs2_i = u2;
        id_ex_mem_read_i = idr; id_ex_rd_i = rd;
        ex_mem_mem_read_i = mr; ex_mem_mem_write_i = mw;
        ex_mem_beq_instruction_i = beq; ex_mem_flag_beq_i = flg;
        mem_ready_i = rdy; clear_counters_i = clr;
        e.name = nm; e.ctrl = ec; e.st = es;
        e.stall = 16'(est); e.flush = 16'(efl); e.err = eerr;
        exp_q.push_back(e);
    endtask

    initial begin
        //    name          rs1 rs2 u2 idr rd mr mw bq fl rdy clr rst  ctrl  st stall fl err
        step("reset",        0,  0, 0, 0,  0, 0, 0, 0, 0, 0,  0,  1, C_NONE, 0, 0, 0, 0);
        step("load_use_rs1", 5,  0, 0, 1,  5, 0, 0, 0, 0, 1,  0,  0, C_LU,   0, 0, 0, 0);
        step("after_bubble", 0,  0, 0, 0,  0, 0, 0, 0, 0, 1,  0,  0, C_NONE, 0, 1, 0, 0);
        step("load_use_rs2", 7,  5, 1, 1,  5, 0, 0, 0, 0, 1,  0,  0, C_LU,   0, 1, 0, 0);
        step("rs2_unused",   3,  5, 0, 1,  5, 0, 0, 0, 0, 1,  0,  0, C_NONE, 0, 2, 0, 0);
        step("load_x0",      0,  0, 1, 1,  0, 0, 0, 0, 0, 1,  0,  0, C_NONE, 0, 2, 0, 0);
        step("br_and_lu",    5,  0, 0, 1,  5, 0, 0, 1, 1, 1,  0,  0, C_BR,   0, 2, 0, 0);
        step("br_not_taken", 5,  0, 0, 1,  5, 0, 0, 1, 0, 1,  0,  0, C_LU,   0, 2, 1, 0);
        step("idle",         0,  0, 0, 0,  0, 0, 0, 0, 0, 1,  0,  0, C_NONE, 0, 3, 1, 0);
        step("store_w1",     0,  0, 0, 0,  0, 0, 1, 0, 0, 0,  0,  0, C_BUSY, 0, 3, 1, 0);
        step("store_w2",     0,  0, 0, 0,  0, 0, 1, 0, 0, 0,  0,  0, C_BUSY, 1, 4, 1, 0);
        step("store_w3",     0,  0, 0, 0,  0, 0, 1, 0, 0, 0,  0,  0, C_BUSY, 1, 5, 1, 0);
        step("store_ready",  0,  0, 0, 0,  0, 0, 1, 0, 0, 1,  0,  0, C_NONE, 1, 6, 1, 0);
        step("store_done",   0,  0, 0, 0,  0, 0, 0, 0, 0, 1,  0,  0, C_NONE, 0, 6, 1, 0);
        step("busy_over_br", 5,  0, 0, 1,  5, 1, 0, 1, 1, 0,  0,  0, C_BUSY, 0, 6, 1, 0);
        step("busy_release", 0,  0, 0, 0,  0, 0, 0, 0, 0, 1,  0,  0, C_NONE, 1, 7, 1, 0);
        step("clear_req",    0,  0, 0, 0,  0, 0, 0, 0, 0, 1,  1,  0, C_NONE, 0, 7, 1, 0);
        step("hang_e1",      0,  0, 0, 0,  0, 1, 0, 0, 0, 0,  0,  0, C_BUSY, 0, 0, 0, 0);
        step("hang_e2",      0,  0, 0, 0,  0, 1, 0, 0, 0, 0,  0,  0, C_BUSY, 1, 1, 0, 0);
        step("hang_e3",      0,  0, 0, 0,  0, 1, 0, 0, 0, 0,  0,  0, C_BUSY, 1, 2, 0, 0);
        step("hang_e4",      0,  0, 0, 0,  0, 1, 0, 0, 0, 0,  0,  0, C_BUSY, 1, 3, 0, 0);
        step("hang_e5",      0,  0, 0, 0,  0, 1, 0, 0, 0, 0,  0,  0, C_BUSY, 1, 4, 0, 0);
        step("error_entry",  0,  0, 0, 0,  0, 1, 0, 0, 0, 0,  0,  0, C_ERR,  2, 5, 0, 1);
        step("error_br_lu",  5,  0, 0, 1,  5, 0, 0, 1, 1, 1,  0,  0, C_ERR,  2, 5, 0, 1);
        step("error_idle",   0,  0, 0, 0,  0, 0, 0, 0, 0, 1,  0,  0, C_ERR,  2, 5, 0, 1);
        step("reset_error",  0,  0, 0, 0,  0, 0, 0, 0, 0, 1,  0,  1, C_NONE, 0, 0, 0, 0);
        step("wait_a",       0,  0, 0, 0,  0, 1, 0, 0, 0, 0,  0,  0, C_BUSY, 0, 0, 0, 0);
        step("wait_b",       0,  0, 0, 0,  0, 1, 0, 0, 0, 0,  0,  0, C_BUSY, 1, 1, 0, 0);
        step("reset_wait",   0,  0, 0, 0,  0, 1, 0, 0, 0, 0,  0,  1, C_BUSY, 0, 0, 0, 0);
        step("post_reset",   0,  0, 0, 0,  0, 0, 0, 0, 0, 1,  0,  0, C_NONE, 0, 0, 0, 0);
        for (int i = 0; i < 65540; i++) begin
            step("saturate", 9, 0, 0, 1, 9, 0, 0, 0, 0, 1, 0, 0, C_LU, 0,
                 (i > 65535) ? 65535 : i, 0, 0);
        end
        step("clear_vs_stall", 9, 0, 0, 1, 9, 0, 0, 0, 0, 1, 1, 0, C_LU,   0, 65535, 0, 0);
        step("cleared",        0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, C_NONE, 0, 0,     0, 0);

        for (int t = 0; t < 10 && exp_q.size() > 0; t++) @(posedge clock_i);
        if (exp_q.size() > 0) begin
            errors = errors + 1;
            $display("FAIL drain: %0d expected responses left, required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pipeline_hazard_controller.md
# pipeline_hazard_controller

Central hazard and sequencing controller for the five-stage pipeline. Each cycle it examines the IF/ID, ID/EX and EX/MEM stage contents and drives the pipeline-register enables, flushes and the PC controls. It resolves load-use stalls, flushes the pipeline on a taken beq, and freezes the pipeline while data memory is busy. A wait-timeout FSM detects a hung memory, and saturating performance counters record stall and flush activity.

## Interface
- MEM_TIMEOUT, 16: maximum WAIT-state count before a memory hang is declared; legal range 1..65535.
- clock  in  1  system clock; FSM and counters update on the rising edge.
- reset  in  1  asynchronous, active-high; clears FSM, wait counter, perf counters, mem_error.
- clear_counters  in  1  synchronous clear of stall_cycles and flush_count.
- if_id_rs1, if_id_rs2  in  5 each  source registers of the instruction in ID.
- if_id_uses_rs2  in  1  ID instruction reads rs2.
- id_ex_mem_read  in  1  instruction in EX is a load.
- id_ex_rd  in  5  destination of the instruction in EX.
- ex_mem_mem_read, ex_mem_mem_write  in  1 each  memory access in MEM stage.
- ex_mem_beq_instruction, ex_mem_flag_beq  in  1 each  beq in MEM, and its compare result.
- mem_ready  in  1  data memory completes its access this cycle.
- pc_write  out  1  PC update enable.
- pc_src_branch  out  1  select branch target for the PC.
- if_id_write, id_ex_write, ex_mem_write  out  1 each  pipeline-register hold enables (0 = hold).
- if_id_flush, id_ex_flush, ex_mem_flush  out  1 each  load zeros (bubble) into the register.
- mem_wb_bubble  out  1  load a bubble into MEM/WB.
- mem_error  out  1  sticky hang indicator.
- state  out  2  FSM state: RUN=0, WAIT=1, ERROR=2.
- stall_cycles, flush_count  out  16 each  saturating performance counters.

## Operation
Event terms (combinational):
- mem_busy = (ex_mem_mem_read | ex_mem_mem_write) & ~mem_ready.
- br_taken = ex_mem_beq_instruction & ex_mem_flag_beq.
- load_use = id_ex_mem_read & (id_ex_rd != 0) & (id_ex_rd == if_id_rs1 | (if_id_uses_rs2 & id_ex_rd == if_id_rs2)).

Control outputs, evaluated in RUN/WAIT with strict priority mem_busy > br_taken > load_use > none:
- mem_busy: every *_write = 0, pc_write = 0, mem_wb_bubble = 1, all flushes = 0, pc_src_branch = 0.
- br_taken: pc_write = 1, pc_src_branch = 1, if_id_flush = id_ex_flush = ex_mem_flush = 1, writes = 1.
- load_use: pc_write = 0, if_id_write = 0, id_ex_flush = 1, other writes = 1.
- none: all writes = 1, all flushes = 0, pc_src_branch = 0, mem_wb_bubble = 0.
- ERROR: all writes = 0, all flushes = 0, pc_src_branch = 0, mem_wb_bubble = 1.

FSM, with a 16-bit wait_cnt:
- RUN: if mem_busy, go to WAIT and set wait_cnt = 1.
- WAIT: if !mem_busy, go to RUN and clear wait_cnt. Otherwise, if wait_cnt == MEM_TIMEOUT, go to ERROR and set mem_error = 1. Otherwise increment wait_cnt.
- ERROR: terminal until reset.

Counters, frozen in ERROR:
- stall_cycles increments on each edge where mem_busy or load_use selects its action.
- flush_count increments on each edge where br_taken selects its action.
- Both saturate at 0xFFFF.
- clear_counters takes precedence over increment.

## Timing
- Control outputs are combinational from the current inputs and state, with zero latency. They are stable before the falling edge, when the pipeline registers sample.
- state, wait_cnt, counters and mem_error update on the rising edge.
- Reset (asserted asynchronously) immediately forces: state = RUN, wait_cnt = 0, stall_cycles = 0, flush_count = 0, mem_error = 0.
- Consequently, during reset the control outputs follow the RUN equations.
- Reset asserted mid-WAIT or in ERROR returns to RUN with no residual state.
- A load-use stall lasts exactly one cycle: the bubble in ID/EX removes the hazard on the next cycle.
- ERROR is entered on the (MEM_TIMEOUT+1)th consecutive rising edge with mem_busy high.
- mem_ready rising on any WAIT cycle returns to RUN at the next edge. No counting occurs in that cycle.
- Simultaneous br_taken and load_use: only the flush actions apply, and only flush_count increments.

## Test plan
- Load x5, then add x6,x5,x7 with mem_ready=1: one cycle with pc_write=0, if_id_write=0, id_ex_flush=1; then normal flow; stall_cycles=1.
- Load into x0, then a dependent instruction: no stall; all writes 1.
- beq taken (both flags 1) while load_use is also true: pc_src_branch=1 and all three flushes=1 for one cycle; flush_count=1; stall_cycles=0.
- MEM_TIMEOUT=4, a load in MEM with mem_ready held 0:
  - state goes RUN to WAIT at the first edge; all writes and pc_write are 0 throughout.
  - ERROR and mem_error=1 after the 5th edge; outputs stay frozen afterwards.
  - Reset returns state to 0 with mem_error=0.
- A store waits 3 cycles, then mem_ready=1: state returns to RUN on the next edge; stall_cycles=3; no error.
- Force stall_cycles to 0xFFFF via sustained load_use: it holds at 0xFFFF. clear_counters together with a stall event yields 0.
